ex_mem_reg: RTL

EX/MEM pipeline boundary of the 32-bit MIPS pipeline CPU: captures the ALU's Result/overflow with the EX-stage control bundle and presents it to the MEM stage through a valid/ready handshake. A 2-entry skid buffer lets MEM stall without a combinational ready path back into EX. It also handles arithmetic overflow for add/sub: it suppresses the faulting instruction's side effects and raises a sticky exception with the faulting PC.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/skid_buf2.sv | 57 +++++
 rtl/ex_mem_reg.sv | 75 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU codes, datapath widths and the EX/MEM entry bundle.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_XOR  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_SUB  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd19;
  localparam logic [4:0] ALU_SLTU = 5'd20;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_t;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] wreg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } ex_mem_t;
  function automatic logic is_addsub(input logic [4:0] code);
    return code == ALU_ADD || code == ALU_SUB;
  endfunction
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: 2-entry valid/ready skid buffer; in_ready is registered so the
// downstream ready never reaches the upstream combinationally.
module skid_buf2
  import mips_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  occ_t         state_q;
  logic         rdy_q;
  logic [W-1:0] head_q, skid_q;
  logic         acc, drn;
  assign acc         = in_valid_i & rdy_q;
  assign drn         = out_valid_o & out_ready_i;
  assign out_valid_o = state_q != S_EMPTY;
  assign in_ready_o  = rdy_q;
  assign out_data_o  = head_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      rdy_q   <= 1'b1;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= S_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: if (acc) begin
          head_q  <= in_data_i;
          state_q <= S_ONE;
        end
        S_ONE: if (acc && drn) head_q <= in_data_i;
        else if (acc) begin
          skid_q  <= in_data_i;
          state_q <= S_TWO;
          rdy_q   <= 1'b0;
        end else if (drn) state_q <= S_EMPTY;
        S_TWO: if (drn) begin
          head_q  <= skid_q;
          state_q <= S_ONE;
          rdy_q   <= 1'b1;
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM boundary; qualifies add/sub overflow into a bubble entry
// and a sticky exception with the faulting PC, buffered through skid_buf2.
module ex_mem_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        ALUCode,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic              overflow,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic [REG_AW-1:0] WriteReg,
  input  logic [DATA_W-1:0] MemWriteData,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult_M,
  output logic [DATA_W-1:0] MemWriteData_M,
  output logic [DATA_W-1:0] PC_M,
  output logic [REG_AW-1:0] WriteReg_M,
  output logic              RegWrite_M,
  output logic              MemRead_M,
  output logic              MemWrite_M,
  output logic              MemtoReg_M,
  output logic              exc_overflow,
  input  logic              exc_ack,
  output logic [DATA_W-1:0] EPC
);
  ex_mem_t           ent, head;
  logic              fault, sk_rdy, acc, exc_q;
  logic [DATA_W-1:0] epc_q;
  assign fault = overflow & is_addsub(ALUCode);
  assign ent = '{result: ALUResult, wdata: MemWriteData, pc: PC_in, wreg: WriteReg,
                 reg_write: RegWrite & ~fault, mem_read: MemRead & ~fault,
                 mem_write: MemWrite & ~fault, mem_to_reg: MemtoReg};
  assign in_ready = sk_rdy & ~exc_q;
  assign acc      = in_valid & in_ready & ~flush;
  skid_buf2 #(.W($bits(ex_mem_t))) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid & ~exc_q),
    .in_ready_o  (sk_rdy),
    .in_data_i   (ent),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head)
  );
  // a pending exception blocks accepts, so only the first fault reaches EPC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_q <= 1'b0;
      epc_q <= '0;
    end else if (acc && fault) begin
      exc_q <= 1'b1;
      epc_q <= PC_in;
    end else if (exc_ack) exc_q <= 1'b0;
  end
  assign ALUResult_M    = head.result;
  assign MemWriteData_M = head.wdata;
  assign PC_M           = head.pc;
  assign WriteReg_M     = head.wreg;
  assign RegWrite_M     = head.reg_write;
  assign MemRead_M      = head.mem_read;
  assign MemWrite_M     = head.mem_write;
  assign MemtoReg_M     = head.mem_to_reg;
  assign exc_overflow   = exc_q;
  assign EPC            = epc_q;
endmodule
